// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: event codes,
// per-button FSM states and a small constant helper.
package button_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Serialized event port: one valid/ready slot carrying button index and type.
interface button_event_ctrl_if #(
  parameter int IDW = 2
);
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [1:0]     evt_type;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_type,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_type,
    output evt_ready
  );
endinterface

// File: rtl/button_event_ctrl_hold_fsm.sv
// Per-button press/hold timer. Raises a one-cycle strobe with the event
// type on press, release, long-hold and auto-repeat.
module button_hold_fsm
  import button_evt_pkg::*;
#(
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      level,
  input  logic      tick,
  output logic      evt_stb,
  output evt_type_e evt_type
);
  localparam int CNT_W = $clog2(max_int(LONG_TICKS, REPEAT_TICKS) + 1);

  hold_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;

  // State, hold counter and previous-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= level;
    end
  end

  // Next state and event strobe; a release outranks a same-cycle threshold.
  always_comb begin
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_inc;
    state_d  = state_q;
    cnt_d    = cnt_q;
    evt_stb  = 1'b0;
    evt_type = EVT_PRESS;
    rise     = level & ~prev_q;
    fall     = ~level & prev_q;
    cnt_inc  = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (rise) begin
          evt_stb  = 1'b1;
          evt_type = EVT_PRESS;
          cnt_d    = '0;
          state_d  = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          evt_stb  = 1'b1;
          evt_type = EVT_RELEASE;
          state_d  = IDLE;
        end else if (tick) begin
          if (cnt_inc == CNT_W'(LONG_TICKS)) begin
            evt_stb  = 1'b1;
            evt_type = EVT_LONG;
            cnt_d    = '0;
            state_d  = HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      HELD: begin
        if (fall) begin
          evt_stb  = 1'b1;
          evt_type = EVT_RELEASE;
          state_d  = IDLE;
        end else if (tick) begin
          if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
            evt_stb  = 1'b1;
            evt_type = EVT_REPEAT;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/clkDivHz.sv
// Free-running prescaler: one-cycle pulse every CLK_FREQ/FREQUENCY clocks.
module clkDivHz #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int FREQUENCY = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic dividedPulse
);
  localparam int DIV = (CLK_FREQ / FREQUENCY < 1) ? 1 : CLK_FREQ / FREQUENCY;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  // Wrap detection and next count.
  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Prescaler counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign dividedPulse = wrap;
endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button hold FSMs feed one pending entry each;
// a round-robin arbiter moves pending entries into a single valid/ready slot.
module button_event_ctrl
  import button_evt_pkg::*;
#(
  parameter int N_BUTTONS    = 4,
  parameter int CLK_FREQ     = 12_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] button_db,
  input  logic                 overflow_clr,
  output logic [N_BUTTONS-1:0] overflow,
  button_event_ctrl_if.master  evt
);
  localparam int IDW = max_int(1, $clog2(N_BUTTONS));

  logic                 tick;
  logic [N_BUTTONS-1:0] stb;
  evt_type_e            stb_type [N_BUTTONS];

  logic [N_BUTTONS-1:0] pend_vld_q, pend_vld_d;
  evt_type_e            pend_type_q [N_BUTTONS];
  evt_type_e            pend_type_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] ovf_set;
  logic [N_BUTTONS-1:0] overflow_q, overflow_d;
  logic [N_BUTTONS-1:0] gnt_vec;

  logic                 slot_vld_q, slot_vld_d;
  logic [IDW-1:0]       slot_id_q, slot_id_d;
  evt_type_e            slot_type_q, slot_type_d;
  logic [IDW-1:0]       rr_q, rr_d;

  clkDivHz #(
    .CLK_FREQ  (CLK_FREQ),
    .FREQUENCY (TICK_HZ)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .dividedPulse (tick)
  );

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_hold_fsm #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .level    (button_db[g]),
      .tick     (tick),
      .evt_stb  (stb[g]),
      .evt_type (stb_type[g])
    );
  end

  // Round-robin pick from rr upward and output slot next state.
  always_comb begin
    logic      load;
    logic      found;
    int        idx;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] rr_next;
    evt_type_e gnt_type;
    load     = !slot_vld_q || evt.evt_ready;
    found    = 1'b0;
    idx      = 0;
    gnt_idx  = '0;
    rr_next  = '0;
    gnt_type = EVT_PRESS;
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      if (!found && pend_vld_q[idx]) begin
        found    = 1'b1;
        gnt_idx  = IDW'(idx);
        gnt_type = pend_type_q[idx];
        rr_next  = (idx + 1 >= N_BUTTONS) ? '0 : IDW'(idx + 1);
      end
    end
    slot_vld_d  = slot_vld_q;
    slot_id_d   = slot_id_q;
    slot_type_d = slot_type_q;
    rr_d        = rr_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      gnt_vec[i] = load && found && (gnt_idx == IDW'(i));
    end
    if (load) begin
      slot_vld_d = found;
      if (found) begin
        slot_id_d   = gnt_idx;
        slot_type_d = gnt_type;
        rr_d        = rr_next;
      end
    end
  end

  // Pending entries: a new event always loads; overwriting an ungranted entry flags overflow.
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      pend_vld_d[i]  = pend_vld_q[i];
      pend_type_d[i] = pend_type_q[i];
      ovf_set[i]     = 1'b0;
      if (stb[i]) begin
        pend_vld_d[i]  = 1'b1;
        pend_type_d[i] = stb_type[i];
        ovf_set[i]     = pend_vld_q[i] && !gnt_vec[i];
      end else if (gnt_vec[i]) begin
        pend_vld_d[i] = 1'b0;
      end
    end
    overflow_d = (overflow_clr ? '0 : overflow_q) | ovf_set;
  end

  // Control and output-slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q  <= '0;
      overflow_q  <= '0;
      slot_vld_q  <= 1'b0;
      slot_id_q   <= '0;
      slot_type_q <= EVT_PRESS;
      rr_q        <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      overflow_q  <= overflow_d;
      slot_vld_q  <= slot_vld_d;
      slot_id_q   <= slot_id_d;
      slot_type_q <= slot_type_d;
      rr_q        <= rr_d;
    end
  end

  // Pending event types are qualified by pend_vld_q and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      pend_type_q[i] <= pend_type_d[i];
    end
  end

  assign evt.evt_valid = slot_vld_q;
  assign evt.evt_id    = slot_id_q;
  assign evt.evt_type  = slot_type_q;
  assign overflow      = overflow_q;
endmodule
